// File: rtl/md_hilo_ctrl_pkg.sv
// Shared encodings, result struct and default latencies for the HI/LO
// multiply/divide sequencer.
package md_hilo_ctrl_pkg;

  localparam logic [2:0] MD_OP_NONE  = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_MULTU = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_DIVU  = 3'd4;
  localparam logic [2:0] MD_OP_MTHI  = 3'd5;
  localparam logic [2:0] MD_OP_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles (and therefore stall D).
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath: {A,B,op} -> {hi,lo}. Holds all the sign,
// divide-by-zero and overflow rules so the controller only sequences.
module md_arith
  import md_hilo_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output md_res_t     res
);

  logic [63:0] prod_s, prod_u;
  logic        is_s;
  logic [31:0] abs_a, abs_b, dva, dvb, q, r;
  logic        neg_q, neg_r;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both flavours; signed div runs on magnitudes
  // and fixes signs afterwards. This also yields 0x80000000/-1 -> q=0x80000000,
  // r=0 without ever performing an overflowing signed divide.
  assign is_s  = (op == MD_OP_DIV);
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign dva   = is_s ? abs_a : a;
  assign dvb   = is_s ? abs_b : b;
  assign q     = (dvb == 32'd0) ? 32'd0 : dva / dvb;
  assign r     = (dvb == 32'd0) ? 32'd0 : dva % dvb;
  assign neg_q = a[31] ^ b[31];
  assign neg_r = a[31];

  always_comb begin
    res = '0;
    case (op)
      MD_OP_MULT:  res = md_res_t'(prod_s);
      MD_OP_MULTU: res = md_res_t'(prod_u);
      MD_OP_DIV: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          res.hi = neg_r ? (~r + 32'd1) : r;
          res.lo = neg_q ? (~q + 32'd1) : q;
        end
      end
      MD_OP_DIVU: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          res.hi = r;
          res.lo = q;
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_hilo_ctrl.sv
// HI/LO owner: issues mult/div with a latency down-counter, commits the
// pending result on the last busy edge, handles mthi/mtlo, cancel and D stall.
module md_hilo_ctrl
  import md_hilo_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_cancel,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_res_t     pend_q, pend_d, res;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  md_arith u_arith (
    .a   (A),
    .b   (B),
    .op  (md_op),
    .res (res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (md_cancel) begin
      // Cancel beats both a same-edge start and the final commit edge.
      state_d = MD_IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else if (state_q == MD_BUSY) begin
      if (cnt_q == CW'(1)) begin
        hi_d    = pend_q.hi;
        lo_d    = pend_q.lo;
        cnt_d   = '0;
        state_d = MD_IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (md_start) begin
      if (md_is_multi(md_op)) begin
        pend_d  = res;
        cnt_d   = md_is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_d = MD_BUSY;
      end else if (md_op == MD_OP_MTHI) begin
        hi_d = A;
      end else if (md_op == MD_OP_MTLO) begin
        lo_d = A;
      end
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Gated by reset so D is never held while the unit is in reset.
  assign stall = reset & md_use_D & (busy | (md_start & md_is_multi(md_op)));

endmodule

// File: doc/md_hilo_ctrl.md
Name: md_hilo_ctrl

Overview:
- Multiply/divide sequencer that owns the HI/LO register pair feeding the writeback select mux (hi and lo sources).
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Models multi-cycle latency with a down-counter and drives the D-stage stall for dependent instructions.
- Supports cancellation of an in-flight op when the issuing instruction is flushed by an exception.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_start  in  1  E-stage instruction is a HI/LO op; sampled each rising edge.
- md_op  in  3  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  in  32  rs operand (E stage, already forwarded).
- B  in  32  rt operand (E stage, already forwarded).
- md_cancel  in  1  flush: abort in-flight op, ignore same-cycle start.
- md_use_D  in  1  D-stage instruction is a mult/div/mthi/mtlo/mfhi/mflo.
- busy  out  1  multi-cycle op in flight.
- stall  out  1  hold D stage.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async, reset low): hi=0, lo=0, busy=0, cnt=0, pending result=0; stall=0 while in reset. Reset mid-operation discards the op.
- States: IDLE (cnt==0) and BUSY (cnt!=0). busy = (cnt!=0), registered.
- Issue in IDLE: md_start=1, md_cancel=0, md_op in 1..4 at edge E0.
  - Compute the 64-bit result from A and B and latch it in a pending register.
  - Set cnt = MULT_CYCLES or DIV_CYCLES; busy is high from E0.
- Result arithmetic:
  - mult: signed 32x32 to 64-bit; {hi,lo} = product.
  - multu: unsigned 32x32 to 64-bit; {hi,lo} = product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / -1: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=A.
- Countdown and commit:
  - In BUSY, each edge decrements cnt.
  - At the edge where cnt==1: hi/lo <= pending, cnt <= 0.
  - Net effect: busy is high exactly N cycles; new hi/lo are visible in the first cycle busy is low.
- mthi/mtlo: single-cycle. At the sampling edge, hi<=A (mthi) or lo<=A (mtlo); busy is unaffected.
- md_start with any op while busy: illegal; the stall prevents it. RTL ignores it; the bench asserts it never occurs.
- stall = md_use_D & (busy | (md_start & md_op in 1..4)). Combinational; covers the issue cycle.
- md_cancel at an edge:
  - Sets cnt <= 0 and busy <= 0; pending is discarded and hi/lo are unchanged.
  - A same-edge md_start (any op, including mthi/mtlo) is ignored.
  - At the same edge as cnt==1, cancel wins: no commit.
- mfhi/mflo reads are done by the WB mux from hi/lo; no read port logic lives here.

Decomposition:
- Shared package: MD_OP_* encodings (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO) and default latency constants.
- One sub-module: md_arith. Purely combinational {A,B,op} -> 64-bit {hi,lo}. Holds the signed/unsigned and divide-by-zero/overflow rules so the controller holds only counter, pending and HI/LO state.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=4 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4. multu A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 -> lo=3, hi=1. div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- Stall: issue mult with md_use_D=1 -> stall=1 in the issue cycle and all 5 busy cycles, 0 in the cycle after. mthi A=0xAA then mtlo A=0x55 on consecutive cycles -> hi=0xAA, lo=0x55, busy never asserted.
- Cancel: div issued, md_cancel at busy cycle 4 -> busy drops next cycle, hi/lo keep prior values. Cancel coincident with the cnt==1 edge -> no commit. Cancel together with md_start of mtlo -> lo unchanged.
- Reset low asynchronously mid-mult (between edges) -> busy, hi, lo go to 0 immediately. After release, a fresh multu 3*5 gives lo=15, hi=0.
